// File: rtl/vpg_pkg.sv
// Shared constants for the video pattern generator: mode encodings and
// the 8-bit-per-channel colour tables that the top scales to CB bits.
package vpg_pkg;

  localparam logic [2:0] MODE_SOLID  = 3'd0;
  localparam logic [2:0] MODE_BARS   = 3'd1;
  localparam logic [2:0] MODE_CHECK  = 3'd2;
  localparam logic [2:0] MODE_SCROLL = 3'd3;
  localparam logic [2:0] MODE_GRAD   = 3'd4;
  localparam logic [2:0] MODE_MARKER = 3'd5;

  // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][23:0] BAR_LUT = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };

  // Shown for the unused mode encodings 6 and 7.
  localparam logic [23:0] ERR_COLOR = 24'hFF00FF;

endpackage

// File: rtl/vpg_bar_tracker.sv
// Tracks which of the 8 colour bars the current active pixel belongs to.
// Both counters clear during blanking; bar_idx saturates on the last bar.
// bar_idx is the bar of the pixel currently on the inputs (pre-edge value).
module vpg_bar_tracker
  import vpg_pkg::*;
#(
  parameter int BAR_W = 160
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       de,
  output logic [2:0] bar_idx
);

  localparam int PW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  logic [PW-1:0] pix_cnt;

  // Count pixels within a bar and step to the next bar at the bar boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (!de) begin
      pix_cnt <= '0;
      bar_idx <= 3'd0;
    end else if (pix_cnt == PW'(BAR_W - 1)) begin
      pix_cnt <= '0;
      if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
    end else begin
      pix_cnt <= pix_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/vpg_pattern_gen.sv
// Two-stage test-pattern generator. Stage 1 captures counters, syncs and
// the per-pixel decisions (checker bit, bar index, mode, frame count);
// stage 2 forms the RGB value. Syncs travel alongside, so every output
// is exactly 2 cycles behind its inputs. No handshake: one pixel per clock.
module vpg_pattern_gen
  import vpg_pkg::*;
#(
  parameter int H_BITS     = 12,
  parameter int V_BITS     = 12,
  parameter int CB         = 8,
  parameter int BAR_W      = 160,
  parameter int CHECK_LOG2 = 5,
  parameter int MARKER_W   = 7,
  parameter bit VS_POL     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [H_BITS-1:0] h_count,
  input  logic [V_BITS-1:0] v_count,
  input  logic              de_in,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic [2:0]        mode,
  input  logic [3*CB-1:0]   bg_color,
  output logic [3*CB-1:0]   rgb_out,
  output logic              de_out,
  output logic              hs_out,
  output logic              vs_out,
  output logic [7:0]        frame_cnt
);

  localparam int W = 3 * CB;
  localparam logic [W-1:0] WHITE = '1;

  // Stretch an 8-bit-per-channel colour to CB bits by repeating each
  // channel from its MSB downwards (truncates to the MSBs when CB < 8).
  function automatic logic [W-1:0] scale24(input logic [23:0] c);
    logic [W-1:0] r;
    r = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int k = 0; k < CB; k++)
        r[ch*CB + CB-1-k] = c[ch*8 + 7 - (k % 8)];
    return r;
  endfunction

  logic       vs_prev;
  logic [2:0] mode_q;
  logic       frame_start;
  logic [2:0] bar_idx;

  assign frame_start = (vs_in == VS_POL) && (vs_prev != VS_POL);

  // Frame counter and mode latch; mode only changes on a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_prev   <= 1'b0;
      frame_cnt <= 8'd0;
      mode_q    <= MODE_SOLID;
    end else begin
      vs_prev <= vs_in;
      if (frame_start) begin
        frame_cnt <= frame_cnt + 8'd1;
        mode_q    <= mode;
      end
    end
  end

  vpg_bar_tracker #(.BAR_W(BAR_W)) u_bar (
    .clk     (clk),
    .rst     (rst),
    .de      (de_in),
    .bar_idx (bar_idx)
  );

  // Scroll mode shifts the checker by the frame count before the bit pick.
  logic [H_BITS-1:0] chk_x;
  logic              chk_bit;
  assign chk_x   = (mode_q == MODE_SCROLL) ? h_count + H_BITS'(frame_cnt) : h_count;
  assign chk_bit = chk_x[CHECK_LOG2] ^ v_count[CHECK_LOG2];

  logic [H_BITS-1:0] s1_h;
  logic [V_BITS-1:0] s1_v;
  logic              s1_de, s1_hs, s1_vs, s1_chk;
  logic [2:0]        s1_bar, s1_mode;
  logic [7:0]        s1_fcnt;

  // Stage 1: capture the pixel with the mode/frame count in force when it arrived.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_h    <= '0;
      s1_v    <= '0;
      s1_de   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_chk  <= 1'b0;
      s1_bar  <= 3'd0;
      s1_mode <= MODE_SOLID;
      s1_fcnt <= 8'd0;
    end else begin
      s1_h    <= h_count;
      s1_v    <= v_count;
      s1_de   <= de_in;
      s1_hs   <= hs_in;
      s1_vs   <= vs_in;
      s1_chk  <= chk_bit;
      s1_bar  <= bar_idx;
      s1_mode <= mode_q;
      s1_fcnt <= frame_cnt;
    end
  end

  logic [W-1:0] pattern;

  // Pattern select for the stage-1 pixel.
  always_comb begin
    pattern = '0;
    case (s1_mode)
      MODE_SOLID:              pattern = bg_color;
      MODE_BARS:               pattern = scale24(BAR_LUT[s1_bar]);
      MODE_CHECK, MODE_SCROLL: pattern = s1_chk ? WHITE : bg_color;
      MODE_GRAD:               pattern = {CB'(s1_h), CB'(s1_v), CB'(s1_fcnt)};
      MODE_MARKER:             pattern = (s1_v == '0 && s1_h < H_BITS'(MARKER_W)) ? '0 : WHITE;
      default:                 pattern = scale24(ERR_COLOR);
    endcase
  end

  // Stage 2: blank outside the active area and realign the syncs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out <= '0;
      de_out  <= 1'b0;
      hs_out  <= 1'b0;
      vs_out  <= 1'b0;
    end else begin
      rgb_out <= s1_de ? pattern : '0;
      de_out  <= s1_de;
      hs_out  <= s1_hs;
      vs_out  <= s1_vs;
    end
  end

endmodule
